// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
// ----------------
// Run controller for the free-running counter datapath. It converts three
// active-low push-buttons into start, pause and clear commands. It steps a
// prescaled N-bit count register through an IDLE/RUN/PAUSE/DONE state
// machine, and the count stops at a latched terminal value.
//
// Parameters:
//   N    count register width (1..32)
//   DIV  CLOCK_50 cycles per count step (>= 2)
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   Reset     in   asynchronous, active-high reset
//   KEY[2:0]  in   active-low raw buttons: [0] start/resume, [1] pause, [2] clear
//   Limit     in   terminal count, latched when a start is taken from IDLE or DONE
//   Count     out  current count
//   State     out  IDLE=00, RUN=01, PAUSE=10, DONE=11
//   Running   out  high while State==RUN
//   Done      out  terminal indication
//
// Build option COUNTER_RUN_CTRL_AUTORELOAD_EN:
//   Defined:   a terminal tick wraps Count to 0, stays in RUN, and pulses
//              Done for one cycle.
//   Undefined: a terminal tick enters DONE, and Done is a level while in DONE.

module counter_run_ctrl #(
    parameter int N   = 8,
    parameter int DIV = 50000000
) (
    input  logic         CLOCK_50,
    input  logic         Reset,
    input  logic [2:0]   KEY,
    input  logic [N-1:0] Limit,
    output logic [N-1:0] Count,
    output logic [1:0]   State,
    output logic         Running,
    output logic         Done
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // Button front end. The flops reset high (released), so no event can
    // appear when Reset is removed.
    logic [2:0] key_meta_q, key_sync_q, key_prev_q;
    logic [2:0] key_fall;
    logic       start_ev, pause_ev, clear_ev;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            key_meta_q <= 3'b111;
            key_sync_q <= 3'b111;
            key_prev_q <= 3'b111;
        end else begin
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    // A high-to-low transition on a synchronised key is one press.
    assign key_fall = key_prev_q & ~key_sync_q;
    assign start_ev = key_fall[0];
    assign pause_ev = key_fall[1];
    assign clear_ev = key_fall[2];

    state_t        state_q, state_d;
    logic [N-1:0]  count_q, count_d;
    logic [N-1:0]  limit_q, limit_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
`ifdef COUNTER_RUN_CTRL_AUTORELOAD_EN
    logic          reload_pulse;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        pre_d   = pre_q;
`ifdef COUNTER_RUN_CTRL_AUTORELOAD_EN
        reload_pulse = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (start_ev) begin
                    state_d = S_RUN;
                    limit_d = Limit;
                    pre_d   = '0;
                end
            end
            S_RUN: begin
                // A command takes precedence over a tick at the same edge.
                // A start in RUN is a no-op, so the tick still proceeds.
                if (clear_ev) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end else if (pause_ev) begin
                    state_d = S_PAUSE;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (count_q != limit_q) begin
                        count_d = count_q + N'(1);
                    end else begin
`ifdef COUNTER_RUN_CTRL_AUTORELOAD_EN
                        count_d      = '0;
                        reload_pulse = 1'b1;
`else
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (clear_ev) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end else if (start_ev) begin
                    // Resume from the held prescaler phase.
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (clear_ev) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end else if (start_ev) begin
                    state_d = S_RUN;
                    count_d = '0;
                    pre_d   = '0;
                    limit_d = Limit;
                end
            end
            default: state_d = S_IDLE;
        endcase

        running_d = (state_d == S_RUN);
`ifdef COUNTER_RUN_CTRL_AUTORELOAD_EN
        done_d = reload_pulse;
`else
        done_d = (state_d == S_DONE);
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            pre_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            pre_q     <= pre_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign Count   = count_q;
    assign State   = state_q;
    assign Running = running_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl with N=8 and DIV=4. The default build
// covers the stop-at-limit behaviour. When COUNTER_RUN_CTRL_AUTORELOAD_EN is
// defined, the auto-reload sequence is checked instead.

module tb_counter_run_ctrl;

    localparam int N   = 8;
    localparam int DIV = 4;

    logic         CLOCK_50 = 1'b0;
    logic         Reset;
    logic [2:0]   KEY;
    logic [N-1:0] Limit;
    logic [N-1:0] Count;
    logic [1:0]   State;
    logic         Running;
    logic         Done;

    int n_chk  = 0;
    int n_pass = 0;

    counter_run_ctrl #(.N(N), .DIV(DIV)) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .KEY      (KEY),
        .Limit    (Limit),
        .Count    (Count),
        .State    (State),
        .Running  (Running),
        .Done     (Done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        KEY   = 3'b111;
        Limit = '0;
        tick(2);
        chk("rst_count",   Count,   0);
        chk("rst_state",   State,   0);
        chk("rst_running", Running, 0);
        chk("rst_done",    Done,    0);
        Reset = 1'b0;
        tick(5);
        chk("post_rst_idle", State, 0);

`ifdef COUNTER_RUN_CTRL_AUTORELOAD_EN
        // Auto-reload with Limit=3: 0,1,2,3,0,... and a one-cycle Done pulse.
        Limit = 8'd3;
        KEY[0] = 1'b0;
        tick(3);
        KEY[0] = 1'b1;
        chk("ar_entry_state", State, 1);
        for (int t = 1; t <= 36; t++) begin
            tick(1);
            chk("ar_count", Count, (t / DIV) % 4);
            chk("ar_state", State, 1);
            chk("ar_done",  Done,  (t % 16 == 0) ? 1 : 0);
        end
`else
        // 1: count to limit 5
        Limit = 8'd5;
        KEY[0] = 1'b0;
        tick(2);
        chk("t1_not_yet", State, 0);
        tick(1);
        KEY[0] = 1'b1;
        chk("t1_entry_state", State, 1);
        chk("t1_entry_run",   Running, 1);
        chk("t1_entry_count", Count, 0);
        for (int k = 1; k <= 5; k++) begin
            tick(3);
            chk("t1_before_step", Count, k - 1);
            tick(1);
            chk("t1_step", Count, k);
            chk("t1_run_done_low", Done, 0);
        end
        tick(3);
        chk("t1_still_run", State, 1);
        tick(1);
        chk("t1_done_state", State, 3);
        chk("t1_done_flag",  Done,  1);
        chk("t1_done_run",   Running, 0);
        chk("t1_done_count", Count, 5);
        tick(10);
        chk("t1_hold_count", Count, 5);

        // 2: restart from DONE, pause at Count=2 with Pre=1, then resume
        KEY[0] = 1'b0;
        tick(3);
        KEY[0] = 1'b1;
        chk("t2_restart_state", State, 1);
        chk("t2_restart_count", Count, 0);
        tick(7);
        KEY[1] = 1'b0;
        tick(3);
        KEY[1] = 1'b1;
        chk("t2_pause_state", State, 2);
        chk("t2_pause_count", Count, 2);
        tick(20);
        chk("t2_hold_state", State, 2);
        chk("t2_hold_count", Count, 2);
        KEY[0] = 1'b0;
        tick(3);
        KEY[0] = 1'b1;
        chk("t2_resume_state", State, 1);
        tick(2);
        chk("t2_resume_pre", Count, 2);
        tick(1);
        chk("t2_resume_step", Count, 3);

        // 3: start and clear in the same cycle at Count=4
        tick(4);
        chk("t3_count4", Count, 4);
        KEY = 3'b010;
        tick(3);
        KEY = 3'b111;
        chk("t3_state", State, 0);
        chk("t3_count", Count, 0);
        tick(6);
        chk("t3_no_start", State, 0);

        // 4: zero limit, then held start gives a single event
        Limit = 8'd0;
        KEY[0] = 1'b0;
        tick(3);
        KEY[0] = 1'b1;
        chk("t4_run", State, 1);
        tick(3);
        chk("t4_run_still", State, 1);
        tick(1);
        chk("t4_done_state", State, 3);
        chk("t4_done_count", Count, 0);
        chk("t4_done_flag",  Done,  1);
        KEY[0] = 1'b0;
        tick(3);
        chk("t4_held_run", State, 1);
        tick(4);
        chk("t4_held_done", State, 3);
        tick(43);
        chk("t4_single_event", State, 3);
        KEY[0] = 1'b1;
        tick(2);
        KEY[1] = 1'b0;
        tick(3);
        KEY[1] = 1'b1;
        chk("t4_pause_ignored", State, 3);
        KEY[2] = 1'b0;
        tick(3);
        KEY[2] = 1'b1;
        chk("t4_clear_idle", State, 0);
        chk("t4_clear_done",  Done,  0);

        // 5: asynchronous reset at Count=3
        Limit = 8'd5;
        KEY[0] = 1'b0;
        tick(3);
        KEY[0] = 1'b1;
        tick(12);
        chk("t5_count3", Count, 3);
        #2;
        Reset = 1'b1;
        #1;
        chk("t5_async_count",   Count,   0);
        chk("t5_async_state",   State,   0);
        chk("t5_async_running", Running, 0);
        #1;
        Reset = 1'b0;
        tick(10);
        chk("t5_no_event_state", State, 0);
        chk("t5_no_event_count", Count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
